token_printer: RTL and testbench

Inverse of the lexer stage. Accepts 16-bit tokens `{kind[15:8], value[7:0]}` in the lexer's encoding and spells each one back out as an ASCII byte stream, followed by a separator byte. Sits between the token/AST side of the pipeline and the byte-oriented output path (UART/text buffer). It is used for debug dumps and for round-trip checking of the lexer.

---
 rtl/token_pkg.sv | 35 +++
 rtl/token_spell.sv | 73 +++++++
 rtl/token_printer.sv | 132 +++++++++++++
 tb/tb_token_printer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/token_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : token_pkg
//  Description : Shared token kind constants, keyword byte strings and the
//                printer FSM state encoding (also imported by the lexer).
//  Revision    : 1.0 - initial release
// ============================================================================
package token_pkg;

   // Token kind codes carried in bits [15:8] of a token
   localparam logic [7:0] CHAR  = 8'd1;
   localparam logic [7:0] FOR   = 8'd2;
   localparam logic [7:0] WHILE = 8'd3;
   localparam logic [7:0] NUM   = 8'd4;
   localparam logic [7:0] EOF   = 8'hFF;

   // Five-byte spelling buffer; element [0] is the first byte emitted
   typedef logic [4:0][7:0] tok_buf_t;

   // Keyword spellings, unused tail bytes zero
   localparam tok_buf_t c_kw_char    = {8'h00, 8'h72, 8'h61, 8'h68, 8'h63};
   localparam tok_buf_t c_kw_for     = {8'h00, 8'h00, 8'h72, 8'h6F, 8'h66};
   localparam tok_buf_t c_kw_while   = {8'h65, 8'h6C, 8'h69, 8'h68, 8'h77};
   localparam tok_buf_t c_kw_unknown = {8'h00, 8'h00, 8'h00, 8'h00, 8'h3F};
   localparam tok_buf_t c_kw_eol     = {8'h00, 8'h00, 8'h00, 8'h00, 8'h0A};

   // Printer FSM states
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EMIT = 2'd1,
      S_SEP  = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/token_spell.sv
`default_nettype none
// ============================================================================
//  Module      : token_spell
//  Description : Combinational token-to-text mapper: keyword ROM plus
//                unsigned decimal conversion of NUM values.
//  Revision    : 1.0 - initial release
// ============================================================================
module token_spell
   import token_pkg::*;
(
   input  logic [7:0] i_kind,
   input  logic [7:0] i_value,
   output tok_buf_t   o_buf,
   output logic [2:0] o_len,
   output logic       o_is_eof
);

   logic [7:0] w_hund;
   logic [7:0] w_tens;
   logic [7:0] w_ones;

   // Decimal digits of the value as ASCII; divisors are constants
   assign w_hund = (i_value / 8'd100) | 8'h30;
   assign w_tens = ((i_value / 8'd10) % 8'd10) | 8'h30;
   assign w_ones = (i_value % 8'd10) | 8'h30;

   // Select spelling and length by kind; NUM drops leading zeros
   always_comb begin
      o_buf    = '0;
      o_len    = 3'd1;
      o_is_eof = 1'b0;
      case (i_kind)
         CHAR: begin
            o_buf = c_kw_char;
            o_len = 3'd4;
         end
         FOR: begin
            o_buf = c_kw_for;
            o_len = 3'd3;
         end
         WHILE: begin
            o_buf = c_kw_while;
            o_len = 3'd5;
         end
         NUM: begin
            if (i_value < 8'd10) begin
               o_buf[0] = w_ones;
               o_len    = 3'd1;
            end else if (i_value < 8'd100) begin
               o_buf[0] = w_tens;
               o_buf[1] = w_ones;
               o_len    = 3'd2;
            end else begin
               o_buf[0] = w_hund;
               o_buf[1] = w_tens;
               o_buf[2] = w_ones;
               o_len    = 3'd3;
            end
         end
         EOF: begin
            o_buf    = c_kw_eol;
            o_len    = 3'd1;
            o_is_eof = 1'b1;
         end
         default: begin
            o_buf = c_kw_unknown;
            o_len = 3'd1;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/token_printer.sv
`default_nettype none
// ============================================================================
//  Module      : token_printer
//  Description : Spells 16-bit lexer tokens back out as an ASCII byte
//                stream, each non-EOF token followed by a separator byte.
//  Revision    : 1.0 - initial release
// ============================================================================
module token_printer
   import token_pkg::*;
#(
   parameter logic [7:0] SEP = 8'h20
)
(
   input  logic        CLK,
   input  logic        RST,
   input  logic        I_VALID,
   input  logic [15:0] I_DATA,
   output logic        I_READY,
   output logic        O_VALID,
   output logic [7:0]  O_DATA,
   input  logic        O_READY
);

   state_t     r_state,   w_state_nxt;
   tok_buf_t   r_buf,     w_buf_nxt;
   logic [2:0] r_len,     w_len_nxt;
   logic [2:0] r_idx,     w_idx_nxt;
   logic       r_is_eof,  w_eof_nxt;
   logic       r_o_valid, w_valid_nxt;
   logic [7:0] r_o_data,  w_data_nxt;

   tok_buf_t   w_spell_buf;
   logic [2:0] w_spell_len;
   logic       w_spell_eof;
   logic       w_accept;
   logic       w_xfer;
   logic       w_last;
   logic [2:0] w_idx_inc;

   token_spell u_spell (
      .i_kind   (I_DATA[15:8]),
      .i_value  (I_DATA[7:0]),
      .o_buf    (w_spell_buf),
      .o_len    (w_spell_len),
      .o_is_eof (w_spell_eof)
   );

   // Ready is gated by reset so it reads 0 for the whole reset window
   assign I_READY   = RST && (r_state == S_IDLE);
   assign O_VALID   = r_o_valid;
   assign O_DATA    = r_o_data;
   assign w_accept  = I_VALID && I_READY;
   assign w_xfer    = r_o_valid && O_READY;
   assign w_last    = (r_idx == (r_len - 3'd1));
   assign w_idx_inc = r_idx + 3'd1;

   // Next-state and next-output logic; the output register is only reloaded
   // when it is empty or its current byte is being taken, so stalls hold it
   always_comb begin
      w_state_nxt = r_state;
      w_buf_nxt   = r_buf;
      w_len_nxt   = r_len;
      w_idx_nxt   = r_idx;
      w_eof_nxt   = r_is_eof;
      w_valid_nxt = r_o_valid;
      w_data_nxt  = r_o_data;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_buf_nxt   = w_spell_buf;
               w_len_nxt   = w_spell_len;
               w_eof_nxt   = w_spell_eof;
               w_idx_nxt   = 3'd0;
               w_state_nxt = S_EMIT;
            end
         end
         S_EMIT: begin
            if (!r_o_valid) begin
               // First cycle after capture: present the first character
               w_valid_nxt = 1'b1;
               w_data_nxt  = r_buf[r_idx];
            end else if (w_xfer) begin
               if (w_last) begin
                  if (r_is_eof) begin
                     w_valid_nxt = 1'b0;
                     w_state_nxt = S_IDLE;
                  end else begin
                     w_data_nxt  = SEP;
                     w_state_nxt = S_SEP;
                  end
               end else begin
                  w_idx_nxt  = w_idx_inc;
                  w_data_nxt = r_buf[w_idx_inc];
               end
            end
         end
         S_SEP: begin
            if (w_xfer) begin
               w_valid_nxt = 1'b0;
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_valid_nxt = 1'b0;
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State, token buffer and output registers with synchronous reset
   always_ff @(posedge CLK) begin
      if (!RST) begin
         r_state   <= S_IDLE;
         r_buf     <= '0;
         r_len     <= 3'd0;
         r_idx     <= 3'd0;
         r_is_eof  <= 1'b0;
         r_o_valid <= 1'b0;
         r_o_data  <= 8'h00;
      end else begin
         r_state   <= w_state_nxt;
         r_buf     <= w_buf_nxt;
         r_len     <= w_len_nxt;
         r_idx     <= w_idx_nxt;
         r_is_eof  <= w_eof_nxt;
         r_o_valid <= w_valid_nxt;
         r_o_data  <= w_data_nxt;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_token_printer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_token_printer
//  Description : Self-checking bench for token_printer with a string-based
//                reference model, directed and randomized tokens.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_token_printer;

   logic        CLK;
   logic        RST;
   logic        I_VALID;
   logic [15:0] I_DATA;
   logic        I_READY;
   logic        O_VALID;
   logic [7:0]  O_DATA;
   logic        O_READY;

   int n_cmp = 0;
   int n_bad = 0;
   int ready_mode = 0;
   int tick_cnt = 0;
   int stall_err = 0;
   int rd = 0;
   logic       prev_stall = 1'b0;
   logic [7:0] prev_data = 8'h00;
   logic [7:0] got[$];
   logic [7:0] exp_q[$];

   token_printer #(.SEP(8'h20)) dut (
      .CLK     (CLK),
      .RST     (RST),
      .I_VALID (I_VALID),
      .I_DATA  (I_DATA),
      .I_READY (I_READY),
      .O_VALID (O_VALID),
      .O_DATA  (O_DATA),
      .O_READY (O_READY)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Observe transfers and held-data behaviour midway between edges
   always @(negedge CLK) begin
      if (!RST) begin
         prev_stall <= 1'b0;
      end else begin
         if (prev_stall && (!O_VALID || O_DATA !== prev_data))
            stall_err <= stall_err + 1;
         if (O_VALID && O_READY)
            got.push_back(O_DATA);
         prev_stall <= O_VALID && !O_READY;
         prev_data  <= O_DATA;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Advance one clock and refresh the downstream ready pattern
   task automatic tick();
      @(posedge CLK);
      #1;
      tick_cnt++;
      case (ready_mode)
         0:       O_READY = 1'b1;
         1:       O_READY = ((tick_cnt % 3) == 0);
         default: O_READY = 1'($urandom_range(0, 1));
      endcase
   endtask

   // Reference spelling: text of the token followed by a space unless EOF
   task automatic model(input logic [15:0] tok);
      string s;
      case (tok[15:8])
         8'd1:    s = "char";
         8'd2:    s = "for";
         8'd3:    s = "while";
         8'd4:    s = $sformatf("%0d", tok[7:0]);
         8'hFF:   s = "\n";
         default: s = "?";
      endcase
      for (int i = 0; i < s.len(); i++) exp_q.push_back(s.getc(i));
      if (tok[15:8] != 8'hFF) exp_q.push_back(8'h20);
   endtask

   task automatic send(input logic [15:0] tok);
      int guard = 0;
      I_VALID = 1'b1;
      I_DATA  = tok;
      while (!I_READY && guard < 100) begin
         tick();
         guard++;
      end
      if (guard >= 100) check("accept_timeout", 32'd0, 32'd1);
      tick();
      I_VALID = 1'b0;
      I_DATA  = 16'($urandom);
   endtask

   // Wait for the token to finish and compare the logged stream to exp_q
   task automatic drain_compare(input string tag);
      int guard = 0;
      int n;
      while (!I_READY && guard < 200) begin
         tick();
         guard++;
      end
      if (guard >= 200) check({tag, "_drain_timeout"}, 32'd0, 32'd1);
      n = got.size() - rd;
      check({tag, "_len"}, 32'(n), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < n) check({tag, "_byte"}, {24'd0, got[rd + i]}, {24'd0, exp_q[i]});
      end
      rd = got.size();
      exp_q.delete();
   endtask

   task automatic run_token(input string tag, input logic [15:0] tok);
      model(tok);
      send(tok);
      drain_compare(tag);
   endtask

   initial begin
      logic [7:0] kinds[10];
      logic [15:0] tok;
      RST = 1'b0;
      I_VALID = 1'b0;
      I_DATA = 16'h0000;
      O_READY = 1'b1;

      // Reset state
      tick();
      tick();
      check("rst_i_ready", 32'(I_READY), 32'd0);
      check("rst_o_valid", 32'(O_VALID), 32'd0);
      check("rst_o_data", {24'd0, O_DATA}, 32'h00);
      RST = 1'b1;
      #1;
      check("rel_i_ready", 32'(I_READY), 32'd1);

      // FOR with exact cycle timing
      ready_mode = 0;
      model(16'h0200);
      send(16'h0200);
      check("for_lat_valid", 32'(O_VALID), 32'd0);
      for (int k = 0; k < 4; k++) begin
         tick();
         check("for_t_valid", 32'(O_VALID), 32'd1);
         check("for_t_data", {24'd0, O_DATA}, {24'd0, exp_q[k]});
      end
      tick();
      check("for_ready_back", 32'(I_READY), 32'd1);
      drain_compare("for");

      // WHILE under a stalling consumer
      ready_mode = 1;
      run_token("while_stall", 16'h0300);
      ready_mode = 0;

      // NUM boundaries, EOF, unknown kind, ignored value
      run_token("num0", 16'h0400);
      run_token("num7", 16'h0407);
      run_token("num100", 16'h0464);
      run_token("num255", 16'h04FF);
      run_token("eof", 16'hFF00);
      run_token("unknown", 16'h0512);
      run_token("char_val", 16'h0155);

      // Back-to-back with I_VALID held and junk while not ready
      model(16'h0100);
      model(16'h0200);
      send(16'h0100);
      I_VALID = 1'b1;
      I_DATA = 16'h0300;
      begin
         int guard = 0;
         while (!I_READY && guard < 100) begin
            tick();
            guard++;
            I_DATA = I_READY ? 16'h0200 : {8'd3, 8'($urandom)};
         end
      end
      tick();
      I_VALID = 1'b0;
      drain_compare("b2b");

      // Reset in the middle of a WHILE token
      ready_mode = 0;
      send(16'h0300);
      tick();
      tick();
      RST = 1'b0;
      tick();
      check("midrst_i_ready", 32'(I_READY), 32'd0);
      check("midrst_o_valid", 32'(O_VALID), 32'd0);
      RST = 1'b1;
      #1;
      check("midrst_ready_back", 32'(I_READY), 32'd1);
      tick();
      check("midrst_quiet", 32'(O_VALID), 32'd0);
      rd = got.size();
      run_token("after_rst", 16'h0100);

      // Randomized tokens with random backpressure
      kinds = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd4, 8'd4, 8'd5, 8'hFF, 8'd0};
      for (int r = 0; r < 40; r++) begin
         ready_mode = int'($urandom_range(0, 2));
         tok[15:8] = kinds[$urandom_range(0, 9)];
         if ($urandom_range(0, 9) == 0) tok[15:8] = 8'($urandom);
         tok[7:0] = 8'($urandom);
         run_token("rand", tok);
      end

      ready_mode = 0;
      tick();
      check("stall_stability", 32'(stall_err), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
